// File: rtl/nw_topic_update.sv
// Read-modify-write engine feeding the nw_topic word-topic count memory.
// Each request: saturating decrement at (word,old), saturating increment at (word,new).
module nw_topic_update #(
  parameter int WORDSIZE   = 32,
  parameter int ADDRSIZE   = 32,
  parameter int WORD_BITS  = 16,
  parameter int TOPIC_BITS = 8,
  parameter int NUM_TOPICS = 64
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [WORD_BITS-1:0]  i_word,
  input  logic [TOPIC_BITS-1:0] i_old_topic,
  input  logic [TOPIC_BITS-1:0] i_new_topic,
  input  logic                  i_init,
  output logic                  o_mem_wen,
  output logic [ADDRSIZE-1:0]   o_mem_addr,
  output logic [WORDSIZE-1:0]   o_mem_wdata,
  input  logic [WORDSIZE-1:0]   i_mem_rdata,
  output logic                  o_done,
  output logic                  o_err_underflow,
  output logic                  o_err_overflow,
  output logic                  o_err_range,
  input  logic                  i_err_clr
);

  typedef enum logic [2:0] {IDLE, RD_OLD, WR_OLD, RD_NEW, WR_NEW, DONE} state_t;

  localparam logic [31:0] NT = 32'(NUM_TOPICS);

  state_t              state_q, state_d;
  logic [ADDRSIZE-1:0] old_addr_q, old_addr_d, new_addr_q, new_addr_d;
  logic                err_uf_q, err_of_q, err_rg_q;
  logic                set_uf, set_of, set_rg;
  logic                accept, range_bad;
  logic [ADDRSIZE-1:0] row_base;

  assign accept    = i_req_valid && (state_q == IDLE);
  assign row_base  = ADDRSIZE'(i_word) * ADDRSIZE'(NUM_TOPICS);
  // The old topic is irrelevant for an initial assignment, so only check it otherwise.
  assign range_bad = (32'(i_new_topic) >= NT) || (!i_init && (32'(i_old_topic) >= NT));

  always_comb begin
    state_d     = state_q;
    old_addr_d  = old_addr_q;
    new_addr_d  = new_addr_q;
    o_mem_wen   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_done      = 1'b0;
    set_uf      = 1'b0;
    set_of      = 1'b0;
    set_rg      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          old_addr_d = row_base + ADDRSIZE'(i_old_topic);
          new_addr_d = row_base + ADDRSIZE'(i_new_topic);
          set_rg     = range_bad;
          if (range_bad || (!i_init && (i_old_topic == i_new_topic))) state_d = DONE;
          else if (i_init)                                             state_d = RD_NEW;
          else                                                         state_d = RD_OLD;
        end
      end
      RD_OLD: begin
        o_mem_addr = old_addr_q;
        state_d    = WR_OLD;
      end
      WR_OLD: begin
        o_mem_addr  = old_addr_q;
        o_mem_wen   = 1'b1;
        set_uf      = (i_mem_rdata == '0);
        o_mem_wdata = set_uf ? '0 : i_mem_rdata - WORDSIZE'(1);
        state_d     = RD_NEW;
      end
      RD_NEW: begin
        o_mem_addr = new_addr_q;
        state_d    = WR_NEW;
      end
      WR_NEW: begin
        o_mem_addr  = new_addr_q;
        o_mem_wen   = 1'b1;
        set_of      = &i_mem_rdata;
        o_mem_wdata = set_of ? i_mem_rdata : i_mem_rdata + WORDSIZE'(1);
        state_d     = DONE;
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      old_addr_q <= '0;
      new_addr_q <= '0;
      err_uf_q   <= 1'b0;
      err_of_q   <= 1'b0;
      err_rg_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      old_addr_q <= old_addr_d;
      new_addr_q <= new_addr_d;
      // A flag raised in the same cycle as a clear must survive.
      err_uf_q   <= set_uf | (err_uf_q & ~i_err_clr);
      err_of_q   <= set_of | (err_of_q & ~i_err_clr);
      err_rg_q   <= set_rg | (err_rg_q & ~i_err_clr);
    end
  end

  assign o_req_ready     = (state_q == IDLE);
  assign o_err_underflow = err_uf_q;
  assign o_err_overflow  = err_of_q;
  assign o_err_range     = err_rg_q;

endmodule
